uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit path (FIFO push interface: send / data_in / fifo_full) among NUM_REQ byte-stream requesters.
- Round-robin grants whole bursts. Each burst is optionally prefixed by a header byte identifying the requester, so the far end can demultiplex.
- Sits between the requester blocks and the UART transmitter top. Drives its send and data_in inputs and observes its fifo_full.

---
 rtl/uart_tx_arb_pkg.sv | 8 +
 rtl/uart_tx_arbiter_rr_pick.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 97 +++++++++
 tb/tb_uart_tx_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared state type, default header byte and ID width helper for the UART TX arbiter
package uart_tx_arb_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker (req, last_grant -> found, pick_id), nearest above last_grant wins
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = id_width(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic               found,
  output logic [IW-1:0]      pick_id
);
  logic [IW-1:0] k;
  always_comb begin
    found = |req;
    pick_id = '0;
    k = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = IW'((int'(last_grant) + i) % NUM_REQ);
      if (req[k]) pick_id = k;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter from NUM_REQ byte streams (req_*) onto one UART TX FIFO push port (tx_*), optional header byte per burst
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter int         MAX_BURST = 8,
  parameter bit         HDR_EN    = 1'b1,
  parameter logic [7:0] HDR_BASE  = HDR_BASE_DEFAULT,
  parameter int         IDLE_TO   = 16,
  localparam int        IW        = id_width(NUM_REQ)
)(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tx_enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_fifo_full,
  output logic [IW-1:0]        grant_id,
  output logic                 busy
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = id_width(IDLE_TO);
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick_id;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] idle_q, idle_d;
  logic found, g_valid, g_last, push;
  logic [7:0] g_data;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req_valid),
    .last_grant(last_q),
    .found(found),
    .pick_id(pick_id)
  );

  always_comb begin
    g_valid = req_valid[grant_q];
    g_last = req_last[grant_q];
    g_data = req_data[{grant_q, 3'b000} +: 8];
    push = state_q == DATA && g_valid && !tx_fifo_full;
    busy = state_q != IDLE;
    grant_id = grant_q;
    tx_send = (state_q == HDR && !tx_fifo_full) || push;
    tx_data = state_q == HDR ? (HDR_BASE | 8'(grant_q)) : state_q == DATA ? g_data : 8'h00;
    req_ready = (state_q == DATA && !tx_fifo_full) ? (NUM_REQ'(1) << grant_q) : '0;
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    beat_d = beat_q;
    idle_d = idle_q;
    if (state_q == IDLE) begin
      if (tx_enable && found) begin
        grant_d = pick_id;
        beat_d = '0;
        idle_d = '0;
        state_d = HDR_EN ? HDR : DATA;
      end
    end else if (state_q == HDR) begin
      if (!tx_fifo_full) state_d = DATA;
    end else if (push) begin
      beat_d = beat_q + 1'b1;
      idle_d = '0;
      if (g_last || beat_d == BW'(MAX_BURST)) begin
        state_d = IDLE;
        last_d = grant_q;
      end
    end else if (g_valid) begin
      idle_d = '0;
    end else if (idle_q == TW'(IDLE_TO - 1)) begin
      state_d = IDLE;
      last_d = grant_q;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      beat_q <= '0;
      idle_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      beat_q <= beat_d;
      idle_q <= idle_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (header and headerless instances)
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n0, reset_n1, tx_enable, tx_fifo_full;
  logic [N-1:0] req_valid, req_last, ready0, ready1, rdy;
  logic [8*N-1:0] req_data;
  logic send0, send1, busy0, busy1, snd, bsy;
  logic [7:0] data0, data1, dat;
  logic [1:0] gid0, gid1, gid;
  bit sel;
  int checks = 0, errors = 0, cycle = 0, busy_cnt = 0;
  logic [8:0] srcq [N][$];
  logic [7:0] txlog[$], expq[$];
  int tcyc[$];

  uart_tx_arbiter u0 (
    .clock(clock), .reset_n(reset_n0), .tx_enable(tx_enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(ready0), .tx_send(send0), .tx_data(data0),
    .tx_fifo_full(tx_fifo_full), .grant_id(gid0), .busy(busy0)
  );

  uart_tx_arbiter #(.HDR_EN(1'b0), .IDLE_TO(4)) u1 (
    .clock(clock), .reset_n(reset_n1), .tx_enable(tx_enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(ready1), .tx_send(send1), .tx_data(data1),
    .tx_fifo_full(tx_fifo_full), .grant_id(gid1), .busy(busy1)
  );

  always_comb begin
    rdy = sel ? ready1 : ready0;
    snd = sel ? send1 : send0;
    dat = sel ? data1 : data0;
    gid = sel ? gid1 : gid0;
    bsy = sel ? busy1 : busy0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input int r, input logic [7:0] d, input bit l);
    srcq[r].push_back({l, d});
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_last[i] = 1'b0;
      req_data[8*i +: 8] = 8'h00;
      if (srcq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = srcq[i][0][7:0];
        req_last[i] = srcq[i][0][8];
      end
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic cyc();
    @(negedge clock);
    if (snd) begin
      txlog.push_back(dat);
      tcyc.push_back(cycle);
    end
    if (bsy) busy_cnt++;
    for (int i = 0; i < N; i++) if (req_valid[i] && rdy[i]) void'(srcq[i].pop_front());
    @(posedge clock);
    #1;
    cycle++;
    drive();
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    do begin
      cyc();
      n++;
    end while ((pending() || bsy) && n < budget);
    chk({tag, "_done"}, {31'd0, pending() || bsy}, 32'd0);
  endtask

  task automatic rst(input bit which);
    sel = which;
    reset_n0 = 1'b0;
    reset_n1 = 1'b0;
    tx_fifo_full = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    cyc();
    cyc();
    if (which) reset_n1 = 1'b1;
    else reset_n0 = 1'b1;
    txlog.delete();
    tcyc.delete();
    busy_cnt = 0;
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, txlog.size(), expq.size());
    for (int i = 0; i < expq.size() && i < txlog.size(); i++)
      chk($sformatf("%s_%0d", tag, i), {24'd0, txlog[i]}, {24'd0, expq[i]});
    txlog.delete();
    expq.delete();
  endtask

  initial begin
    tx_enable = 1'b1;
    rst(1'b0);
    chk("rst_send", {31'd0, snd}, 0);
    chk("rst_data", {24'd0, dat}, 0);
    chk("rst_ready", {28'd0, rdy}, 0);
    chk("rst_busy", {31'd0, bsy}, 0);
    chk("rst_gid", {30'd0, gid}, 0);

    put(0, 8'h11, 0); put(0, 8'h22, 0); put(0, 8'h33, 1);
    drive();
    run("single", 50);
    expq = '{8'hA0, 8'h11, 8'h22, 8'h33};
    chk_log("single");
    chk("single_busy_cycles", busy_cnt, 4);
    chk("single_idle_data", {24'd0, dat}, 0);
    chk("single_gid", {30'd0, gid}, 0);

    tx_enable = 1'b0;
    put(1, 8'h55, 1);
    drive();
    repeat (3) cyc();
    chk("en_off_busy", {31'd0, bsy}, 0);
    chk("en_off_log", txlog.size(), 0);
    tx_enable = 1'b1;
    run("en_on", 20);
    expq = '{8'hA1, 8'h55};
    chk_log("en_on");
    chk("en_on_gid", {30'd0, gid}, 1);

    rst(1'b0);
    put(0, 8'h01, 0); put(0, 8'h02, 1); put(0, 8'h03, 0); put(0, 8'h04, 1);
    put(1, 8'h11, 0); put(1, 8'h12, 1);
    put(2, 8'h21, 0); put(2, 8'h22, 1);
    put(3, 8'h31, 0); put(3, 8'h32, 1);
    drive();
    run("rr", 100);
    expq = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12, 8'hA2, 8'h21, 8'h22,
             8'hA3, 8'h31, 8'h32, 8'hA0, 8'h03, 8'h04};
    chk_log("rr");

    rst(1'b0);
    for (int i = 0; i < 20; i++) put(1, 8'h40 + 8'(i), 0);
    put(2, 8'h60, 1); put(2, 8'h61, 1);
    drive();
    run("burst", 300);
    expq.push_back(8'hA1);
    for (int i = 0; i < 8; i++) expq.push_back(8'h40 + 8'(i));
    expq.push_back(8'hA2); expq.push_back(8'h60); expq.push_back(8'hA1);
    for (int i = 8; i < 16; i++) expq.push_back(8'h40 + 8'(i));
    expq.push_back(8'hA2); expq.push_back(8'h61); expq.push_back(8'hA1);
    for (int i = 16; i < 20; i++) expq.push_back(8'h40 + 8'(i));
    chk_log("burst");

    rst(1'b0);
    put(0, 8'h81, 0); put(1, 8'h91, 1);
    drive();
    run("tmo", 100);
    chk("tmo_gap", tcyc.size() >= 3 ? tcyc[2] - tcyc[1] : -1, 18);
    expq = '{8'hA0, 8'h81, 8'hA1, 8'h91};
    chk_log("tmo");

    rst(1'b1);
    put(0, 8'h71, 0); put(0, 8'h72, 0); put(0, 8'h73, 0); put(0, 8'h74, 0); put(0, 8'h75, 1);
    drive();
    repeat (3) cyc();
    tx_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_send_%0d", i), {31'd0, snd}, 0);
      chk($sformatf("bp_ready_%0d", i), {28'd0, rdy}, 0);
      chk($sformatf("bp_busy_%0d", i), {31'd0, bsy}, 1);
      cyc();
    end
    tx_fifo_full = 1'b0;
    run("bp", 50);
    expq = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    chk_log("bp");

    rst(1'b1);
    put(2, 8'hC1, 0); put(2, 8'hC2, 0); put(2, 8'hC3, 0); put(2, 8'hC4, 0); put(2, 8'hC5, 1);
    drive();
    repeat (3) cyc();
    chk("rm_gid_pre", {30'd0, gid}, 2);
    reset_n1 = 1'b0;
    cyc();
    chk("rm_send", {31'd0, snd}, 0);
    chk("rm_gid", {30'd0, gid}, 0);
    chk("rm_busy", {31'd0, bsy}, 0);
    chk("rm_ready", {28'd0, rdy}, 0);
    cyc();
    srcq[2].delete();
    reset_n1 = 1'b1;
    put(1, 8'hD1, 0); put(1, 8'hD2, 1);
    drive();
    run("rm", 30);
    expq = '{8'hC1, 8'hC2, 8'hC3, 8'hD1, 8'hD2};
    chk_log("rm");
    chk("rm_gid_post", {30'd0, gid}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
